// File: rtl/riscv_pkg.sv
// Core-wide constants: opcodes, IO register selects and
// the seven-segment glyph table shared by the MMIO stage.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [1:0] IO_SWITCH = 2'b00;
  localparam logic [1:0] IO_LED    = 2'b01;
  localparam logic [1:0] IO_SEG    = 2'b10;
  localparam logic [1:0] IO_BTN    = 2'b11;

  // Active-low {g..a}; entry N is the glyph for hex digit N.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [7:0] seg_decode(
    input logic [3:0] nib
  );
    return {1'b1, SEG_HEX[nib]};
  endfunction

endpackage

// File: rtl/mmio_unit_if.sv
// Load/store bus between the controller side and the
// memory/IO split stage.
interface mmio_unit_if;

  logic        mem_read;
  logic        mem_write;
  logic        io_read;
  logic        io_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] rdata;
  logic        mem_we;

  modport master (
    output mem_read,
    output mem_write,
    output io_read,
    output io_write,
    output addr,
    output wdata,
    output mem_rdata,
    input  rdata,
    input  mem_we
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  io_read,
    input  io_write,
    input  addr,
    input  wdata,
    input  mem_rdata,
    output rdata,
    output mem_we
  );

endinterface

// File: rtl/mmio_unit_debounce.sv
// Button conditioner: 2-flop sync, stability counter,
// accepted level and a one-cycle rising-edge strobe.
module mmio_unit_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic        s1;
  logic        s2;
  logic [19:0] cnt;
  logic        hit;

  assign hit  = (s2 != level) &&
                (cnt == DEBOUNCE_CYCLES - 20'd1);
  assign rise = hit & ~level;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (hit) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/mmio_unit.sv
// Memory/IO split stage: routes loads/stores to data memory
// or the board IO registers and scans the 8-digit display.
module mmio_unit
  import riscv_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [16:0] SCAN_DIV        = 17'd100000,
  parameter int          SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                rst,
  mmio_unit_if.slave          bus,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                button,
  output logic [SW_WIDTH-1:0] led,
  output logic [7:0]          seg_an,
  output logic [7:0]          seg_cat
);

  logic [SW_WIDTH-1:0] sw_s1;
  logic [SW_WIDTH-1:0] sw_s2;
  logic [31:0]         seg_reg;
  logic [16:0]         scan_cnt;
  logic [2:0]          dig_idx;
  logic                btn_level;
  logic                btn_rise;
  logic                press_sticky;
  logic [1:0]          sel;
  logic [31:0]         io_word;
  logic                led_wr;
  logic                seg_wr;
  logic                btn_rd;
  logic                unused_addr;

  assign sel         = bus.addr[3:2];
  assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

  assign led_wr = bus.io_write && (sel == IO_LED);
  assign seg_wr = bus.io_write && (sel == IO_SEG);
  assign btn_rd = bus.io_read  && (sel == IO_BTN);

  mmio_unit_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .raw  (button),
    .level(btn_level),
    .rise (btn_rise)
  );

  always_comb begin
    io_word = '0;
    unique case (sel)
      IO_SWITCH: io_word = 32'(sw_s2);
      IO_LED:    io_word = 32'(led);
      IO_SEG:    io_word = seg_reg;
      IO_BTN:    io_word = {30'b0, btn_level, press_sticky};
    endcase
  end

  // IO wins over memory when both read strobes are up.
  always_comb begin
    bus.rdata = '0;
    if (bus.io_read) begin
      bus.rdata = io_word;
    end else if (bus.mem_read) begin
      bus.rdata = bus.mem_rdata;
    end
  end

  assign bus.mem_we = bus.mem_write & ~bus.io_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1        <= '0;
      sw_s2        <= '0;
      led          <= '0;
      seg_reg      <= '0;
      press_sticky <= 1'b0;
    end else begin
      sw_s1 <= switches;
      sw_s2 <= sw_s1;
      if (led_wr) begin
        led <= bus.wdata[SW_WIDTH-1:0];
      end
      if (seg_wr) begin
        seg_reg <= bus.wdata;
      end
      if (btn_rise) begin
        press_sticky <= 1'b1;
      end else if (btn_rd) begin
        press_sticky <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == SCAN_DIV - 17'd1) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 17'd1;
    end
  end

  assign seg_an  = ~(8'd1 << dig_idx);
  assign seg_cat = seg_decode(seg_reg[{dig_idx, 2'b00} +: 4]);

endmodule

// File: doc/mmio_unit.md
Name: mmio_unit

Overview:
- Memory/IO split stage sitting directly downstream of the main decoder/controller.
- Consumes mem_read, mem_write, io_read, io_write and the ALU address, and owns the board IO registers: LEDs, 8-digit seven-segment display, switch input and debounced button.
- Returns the writeback word (data memory or IO) to the register-file write mux.

Parameters:
- DEBOUNCE_CYCLES, 20'd500000: consecutive stable samples required before the button level is accepted.
- SCAN_DIV, 17'd100000: clk cycles per seven-segment digit slot.
- SW_WIDTH, 16: switch/LED width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_read  in  1  load targets data memory
- mem_write  in  1  store targets data memory
- io_read  in  1  load targets IO region
- io_write  in  1  store targets IO region
- addr  in  32  ALU result (byte address)
- wdata  in  32  store data (rs2)
- mem_rdata  in  32  data-memory read word
- switches  in  SW_WIDTH  raw board switches (asynchronous)
- button  in  1  raw board button (asynchronous, bouncy)
- rdata  out  32  word to writeback mux
- mem_we  out  1  data-memory write enable
- led  out  SW_WIDTH  LED drive
- seg_an  out  8  digit enables, active-low
- seg_cat  out  8  segment cathodes, active-low, {dp,g..a}

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - led=0, seg register=0, scan counter=0, digit index=0.
  - Both synchronizer stages=0, debounce counter=0, stable button=0, press_sticky=0.
  - seg_an=8'hFE, seg_cat shows digit 0 of value 0 (8'hC0).
  - rst mid-debounce discards the count.
- IO register select is addr[3:2], qualified by io_read/io_write:
  - 00 SWITCH: read only; returns zero-extended 2-flop-synchronized switches. Writes ignored.
  - 01 LED: r/w; write loads wdata[SW_WIDTH-1:0] at the next edge; read returns zero-extended led.
  - 10 SEG: r/w; 32-bit value shown as 8 hex digits.
  - 11 BTN: read returns {30'b0, stable_level, press_sticky}. The read clears press_sticky at the same edge. Writes ignored.
- rdata is combinational:
  - io_read=1 gives the IO word.
  - else mem_read=1 gives mem_rdata.
  - else 32'b0.
  - Register reads show pre-edge values, so a write and read in one cycle see the old value.
- mem_we = mem_write & ~io_write. io_write never reaches memory.
- io_read and io_write high together: write performed, rdata still the pre-edge read.
- Switch path: 2-flop synchronizer, 2-cycle latency to rdata.
- Button path, after a 2-flop synchronizer:
  - If the synced level differs from stable_level, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable_level toggles and the counter clears.
  - A 0->1 stable transition sets press_sticky.
  - A set event in the same cycle as a BTN read leaves press_sticky=1 (set wins over clear).
- Seven-segment scan:
  - Counter wraps at SCAN_DIV-1 and advances the digit index 0..7, wrapping 7->0.
  - seg_an = ~(1<<index).
  - seg_cat = hex-to-segment decode of seg_reg[4*index+3 : 4*index], with dp off.
  - A seg write takes effect on the currently lit digit at the next edge.
- Counters are unsigned and wrap silently; no overflow beyond the stated wraps.

Decomposition:
- Shared package (riscv_pkg, alongside the opcode constants):
  - IO_SWITCH/IO_LED/IO_SEG/IO_BTN 2-bit selects.
  - Active-low hex-to-segment constant table.
- One natural sub-module: debounce (sync + counter + stable level + rising-edge pulse), parameterised by DEBOUNCE_CYCLES.
- Seven-segment scan stays inline.

Test Plan (DEBOUNCE_CYCLES=4, SCAN_DIV=4 for sim):
- Reset then idle: after rst, led=0, seg_an=8'hFE, seg_cat=8'hC0, rdata=0 with all strobes low; mem_we=0.
- LED write/read: io_write=1, addr[3:2]=01, wdata=32'h0000A5A5 for one cycle -> led=16'hA5A5 next cycle. Then io_read=1, same addr -> rdata=32'h0000A5A5.
- Memory passthrough: mem_read=1, mem_rdata=32'hDEADBEEF -> rdata=32'hDEADBEEF. mem_write=1 with io_write=1 -> mem_we=0.
- Switch sync: switches 0->16'h1234 -> SWITCH read returns 0 for 2 edges, 32'h00001234 from the 3rd edge.
- Debounce and sticky:
  - button toggles 1,0,1 on successive cycles -> press_sticky stays 0.
  - button held 1 for 2+4 cycles -> BTN read gives 32'h3, and press_sticky=0 after that read edge.
  - A BTN read coinciding with a new stable rising edge -> press_sticky remains 1.
- Seg scan: seg write 32'h76543210 -> over 32 cycles, seg_an steps FE,FD,...,7F, with seg_cat for digit1=8'hF9 and digit7=8'hF8, then wraps to FE.
